// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed 7-segment scan controller for a signed BCD
//               value. Optional build macro LEADING_ZERO_BLANK_EN blanks
//               magnitude digits above the most significant nonzero digit.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  sign_in,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic                  pending,
    output logic                  frame_done,
    output logic [N_DIGITS:0]     an,
    output logic [6:0]            seg
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = $clog2(N_DIGITS + 1);

    localparam logic [PW-1:0] c_presc_max = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] c_guard     = PW'(GUARD_CYCLES);
    localparam logic [SW-1:0] c_sign_slot = SW'(N_DIGITS);
    localparam logic [6:0]    c_blank     = 7'b1111111;
    localparam logic [6:0]    c_minus     = 7'b0111111;

    logic [PW-1:0]         r_presc;
    logic [SW-1:0]         r_slot;
    logic                  r_pending;
    logic                  r_frame_done;
    logic                  r_shadow_sign;
    logic [4*N_DIGITS-1:0] r_shadow_bcd;
    logic                  r_disp_sign;
    logic [4*N_DIGITS-1:0] r_disp_bcd;
    logic [N_DIGITS:0]     r_an;
    logic [6:0]            r_seg;

    logic                  w_tc;
    logic                  w_wrap;
    logic                  w_guard;
    logic [3:0]            w_digit;
    logic                  w_digit_blank;
    logic [N_DIGITS-1:0]   w_lz;
    logic [N_DIGITS:0]     w_an_next;
    logic [6:0]            w_seg_next;

    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        case (d)
            4'd0:    f_seg7 = 7'b1000000;
            4'd1:    f_seg7 = 7'b1111001;
            4'd2:    f_seg7 = 7'b0100100;
            4'd3:    f_seg7 = 7'b0110000;
            4'd4:    f_seg7 = 7'b0011001;
            4'd5:    f_seg7 = 7'b0010010;
            4'd6:    f_seg7 = 7'b0000010;
            4'd7:    f_seg7 = 7'b1111000;
            4'd8:    f_seg7 = 7'b0000000;
            4'd9:    f_seg7 = 7'b0010000;
            default: f_seg7 = 7'b1111111;
        endcase
    endfunction

    assign w_tc    = (r_presc == c_presc_max);
    assign w_wrap  = w_tc && (r_slot == c_sign_slot);
    assign w_guard = (r_presc < c_guard);

`ifdef LEADING_ZERO_BLANK_EN
    logic w_run;

    // Walk down from the top digit; digit 0 is never blanked.
    always_comb begin
        w_lz  = '0;
        w_run = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            w_run   = w_run & (r_disp_bcd[4*i +: 4] == 4'd0);
            w_lz[i] = w_run;
        end
    end
`else
    assign w_lz = '0;
`endif

    always_comb begin
        w_digit       = '0;
        w_digit_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_slot == SW'(i)) begin
                w_digit       = r_disp_bcd[4*i +: 4];
                w_digit_blank = w_lz[i];
            end
        end
    end

    always_comb begin
        w_an_next  = '1;
        w_seg_next = c_blank;
        if (!w_guard) begin
            for (int i = 0; i <= N_DIGITS; i++) begin
                if (r_slot == SW'(i)) begin
                    w_an_next[i] = 1'b0;
                end
            end
            if (r_slot == c_sign_slot) begin
                w_seg_next = r_disp_sign ? c_minus : c_blank;
            end else if (!w_digit_blank) begin
                w_seg_next = f_seg7(w_digit);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc       <= '0;
            r_slot        <= '0;
            r_pending     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_shadow_sign <= 1'b0;
            r_shadow_bcd  <= '0;
            r_disp_sign   <= 1'b0;
            r_disp_bcd    <= '0;
            r_an          <= '1;
            r_seg         <= c_blank;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tc) begin
                r_presc <= '0;
                r_slot  <= w_wrap ? '0 : r_slot + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            // Commit sees the pre-load shadow, so a load on the wrap cycle waits a frame.
            if (w_wrap && r_pending) begin
                r_disp_sign <= r_shadow_sign;
                r_disp_bcd  <= r_shadow_bcd;
            end
            if (load) begin
                r_shadow_sign <= sign_in;
                r_shadow_bcd  <= bcd_in;
                r_pending     <= 1'b1;
            end else if (w_wrap) begin
                r_pending     <= 1'b0;
            end
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign pending    = r_pending;
    assign frame_done = r_frame_done;
    assign an         = r_an;
    assign seg        = r_seg;

endmodule
`default_nettype wire
